// File: rtl/dmem_mmio_pkg.sv
// Shared constants and decode helpers for the data-memory / MMIO stage.
// MMIO register offsets, STATUS bit layout and the address-region type live here.
package dmem_mmio_pkg;

    localparam logic [31:0] OFF_TXDATA = 32'h0;
    localparam logic [31:0] OFF_STATUS = 32'h4;
    localparam logic [31:0] OFF_CYCLE  = 32'h8;
    localparam logic [31:0] OFF_LED    = 32'hC;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic [2:0] {
        RGN_NONE,
        RGN_RAM,
        RGN_TXDATA,
        RGN_STATUS,
        RGN_CYCLE,
        RGN_LED
    } region_e;

    // Word-granular match: the two byte-offset bits never take part.
    function automatic logic mmio_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] off);
        logic [31:0] target;
        target = base + off;
        return addr[31:2] == target[31:2];
    endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// Core-side load/store bus plus the TX byte stream and LED output of dmem_mmio.
interface dmem_mmio_if;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  leds;

    modport master (
        output MemWrite, Addr, WriteData, tx_ready,
        input  ReadData, tx_data, tx_valid, leds
    );

    modport slave (
        input  MemWrite, Addr, WriteData, tx_ready,
        output ReadData, tx_data, tx_valid, leds
    );
endinterface

// File: rtl/dmem_mmio_tx_fifo.sv
// Synchronous FIFO with occupancy count and a drop strobe for pushes refused while full.
// A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pop_ok, push_ok;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign dout  = empty ? '0 : mem[rd_q];

    always_comb begin
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        drop    = push && full && !pop_ok;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (push_ok) wr_d = wr_q + AW'(1);
        if (pop_ok)  rd_d = rd_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage carries no reset; emptiness is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_q] <= din;
    end
endmodule

// File: rtl/dmem_mmio.sv
// Data-memory stage for the single-cycle core: word RAM with combinational read plus
// an MMIO window holding TX FIFO, STATUS, free-running CYCLE counter and LED register.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    dmem_mmio_if.slave  bus
);
    localparam int          IW        = $clog2(DEPTH_WORDS);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

    region_e       region;
    logic [IW-1:0] ram_idx;
    logic [31:0]   ram [DEPTH_WORDS];

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;

    logic [31:0]   cyc_q, cyc_d;
    logic [7:0]    led_q, led_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   rdata;

    always_comb begin
        region = RGN_NONE;
        if (bus.Addr < RAM_BYTES)                          region = RGN_RAM;
        else if (mmio_hit(bus.Addr, MMIO_BASE, OFF_TXDATA)) region = RGN_TXDATA;
        else if (mmio_hit(bus.Addr, MMIO_BASE, OFF_STATUS)) region = RGN_STATUS;
        else if (mmio_hit(bus.Addr, MMIO_BASE, OFF_CYCLE))  region = RGN_CYCLE;
        else if (mmio_hit(bus.Addr, MMIO_BASE, OFF_LED))    region = RGN_LED;
    end

    assign ram_idx = bus.Addr[IW+1:2];

    assign fifo_push = bus.MemWrite && (region == RGN_TXDATA);
    assign fifo_pop  = !fifo_empty && bus.tx_ready;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.WriteData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .drop  (fifo_drop)
    );

    assign bus.tx_data  = fifo_dout;
    assign bus.tx_valid = !fifo_empty;
    assign bus.leds     = led_q;

    always_comb begin
        ovf_d = ovf_q;
        cyc_d = cyc_q + 32'd1;
        led_d = led_q;
        if (bus.MemWrite && region == RGN_STATUS && bus.WriteData[ST_OVF]) ovf_d = 1'b0;
        // A drop in the same cycle as a clear leaves the flag set.
        if (fifo_drop) ovf_d = 1'b1;
        if (bus.MemWrite && region == RGN_CYCLE) cyc_d = bus.WriteData;
        if (bus.MemWrite && region == RGN_LED)   led_d = bus.WriteData[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            cyc_q <= '0;
            led_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            cyc_q <= cyc_d;
            led_q <= led_d;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.MemWrite && region == RGN_RAM) ram[ram_idx] <= bus.WriteData;
    end

    // Loads are combinational so the core sees data in the same cycle.
    always_comb begin
        rdata = '0;
        case (region)
            RGN_RAM:    rdata = ram[ram_idx];
            RGN_STATUS: begin
                rdata[ST_FULL]            = fifo_full;
                rdata[ST_EMPTY]           = fifo_empty;
                rdata[ST_OVF]             = ovf_q;
                rdata[ST_CNT_LSB +: CW]   = fifo_count;
            end
            RGN_CYCLE:  rdata = cyc_q;
            RGN_LED:    rdata = {24'h0, led_q};
            default:    rdata = '0;
        endcase
    end

    assign bus.ReadData = rdata;
endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-side memory stage sitting directly downstream of the single-cycle RISC-V core.
- Consumes the core's MemWrite, address (ALUResult) and WriteData, and returns ReadData in the same cycle.
- Provides a word RAM and a small MMIO window: a TX byte FIFO with a valid/ready output, a free-running cycle counter, and an LED register.
- All state updates occur on the rising clk edge; reads are combinational, as the single-cycle core requires.

Parameters:
- DEPTH_WORDS, 256: RAM size in 32-bit words; power of 2.
- FIFO_DEPTH, 8: TX FIFO entries; power of 2, at least 2.
- MMIO_BASE, 32'h0000_1000: byte address of the MMIO window; must be at least 4*DEPTH_WORDS.

Ports:
- clk, in, 1: sole clock, rising edge.
- rst, in, 1: reset; asynchronous, active-low (0 = reset).
- MemWrite, in, 1: store strobe from core.
- Addr, in, 32: byte address (core ALUResult); bits [1:0] ignored (word access only).
- WriteData, in, 32: store data.
- ReadData, out, 32: load data, combinational from Addr.
- tx_data, out, 8: FIFO head byte.
- tx_valid, out, 1: FIFO non-empty.
- tx_ready, in, 1: downstream accepts head when tx_valid && tx_ready at a clk edge.
- leds, out, 8: LED register.

Behaviour:
- Decode (word-aligned):
  - RAM when Addr < 4*DEPTH_WORDS; index = Addr[log2(DEPTH_WORDS)+1:2].
  - MMIO_BASE+0x0 TXDATA: write pushes WriteData[7:0]; read returns 0.
  - MMIO_BASE+0x4 STATUS, read-only except the W1C bit:
    - bit0 full, bit1 empty, bit2 overflow (sticky), bits[15:8] count; all other bits 0.
    - Writing bit2=1 clears overflow.
  - MMIO_BASE+0x8 CYCLE: reads the counter; a write loads WriteData.
  - MMIO_BASE+0xC LED: R/W; bits[7:0] used, upper bits read 0.
  - Any other address reads 32'h0; writes to it are ignored.
- RAM:
  - A write lands at the clk edge when MemWrite=1.
  - A read of the same address in the same cycle returns the old value.
  - RAM is not reset; contents after reset are undefined.
- Reset (rst=0, async):
  - FIFO empty, so tx_valid=0 and tx_data=0.
  - overflow=0, CYCLE=0, leds=0.
  - ReadData still decodes combinationally.
  - Reset mid-transfer discards all FIFO contents.
- FIFO:
  - push = MemWrite && Addr==TXDATA; pop = tx_valid && tx_ready.
  - Latency: a push at edge N makes tx_valid=1 from edge N onward. There is no same-cycle bypass, so an empty FIFO never presents the byte being written.
  - tx_data = head entry when non-empty, 8'h00 when empty.
  - Push while full and no pop: byte is dropped, overflow set, count unchanged.
  - Push and pop together when full: both take effect, count unchanged, no overflow.
  - Push and pop together when non-full and non-empty: count unchanged.
  - Pop while empty cannot occur, because tx_valid=0.
  - Read/write pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
  - If an overflow-clear write and an overflow event occur in the same cycle, set wins.
- CYCLE:
  - Increments by 1 every edge out of reset and wraps 32'hFFFF_FFFF -> 0.
  - A software write has priority over the increment. The loaded value appears at the next edge, and increment resumes after it.
- Width rules: a TXDATA write ignores WriteData[31:8]; a LED write ignores WriteData[31:8].

Decomposition:
- Shared package dmem_mmio_pkg holds:
  - MMIO offset constants (OFF_TXDATA=0, OFF_STATUS=4, OFF_CYCLE=8, OFF_LED=12).
  - STATUS bit positions (ST_FULL=0, ST_EMPTY=1, ST_OVF=2, ST_CNT_LSB=8).
- One sub-module, tx_fifo: a parameterised synchronous FIFO with push/pop, full/empty/count and async active-low reset.
- Decode, RAM, CYCLE and LED logic stay in dmem_mmio.

Test Plan:
- RAM store/load: write 32'hDEADBEEF to 0x10, then read 0x10 -> ReadData=DEADBEEF. Read 0x14 in the same cycle as a store to it -> old value returned.
- FIFO handshake:
  - With tx_ready=0, push bytes 0x41, 0x42, 0x43 -> tx_valid=1, tx_data=0x41, STATUS count=3.
  - Raise tx_ready -> bytes leave in order 41, 42, 43 over 3 edges, then tx_valid=0, STATUS=32'h0000_0002.
- Overflow:
  - With tx_ready=0, push 9 bytes -> STATUS bit0=1, bit2=1, count=8, and the 9th byte is absent on drain.
  - Write STATUS=4 -> bit2 clears.
- Full with simultaneous push+pop: FIFO full, tx_ready=1, push 0x55 -> count stays 8, overflow stays 0, 0x55 appears as the last byte.
- CYCLE and LED:
  - Write CYCLE=32'hFFFF_FFFE -> reads FFFF_FFFE, FFFF_FFFF, 0000_0000 on successive cycles.
  - LED write 32'h1234_56A5 -> leds=8'hA5, LED readback=32'h0000_00A5.
- Async reset mid-drain: assert rst=0 between edges with 3 bytes queued -> tx_valid=0, leds=0, CYCLE=0 immediately, without waiting for a clk edge; no bytes are emitted after release.
